// File: rtl/scan_drv_pkg.sv
// Shared types and constants for the scan test driver (states, MISR polynomial).
package scan_drv_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CAPTURE = 3'd2,
      UNLOAD  = 3'd3,
      RESP    = 3'd4
   } state_e;

   localparam logic [15:0] MISR_POLY = 16'h8016;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/scan_misr.sv
// Internal-XOR (Galois) multiple-input signature register.
// Used by scan_test_driver only when SCAN_DRV_MISR_EN is defined.
module scan_misr
   import scan_drv_pkg::*;
#(
   parameter int                    MISR_WIDTH = 16,
   parameter logic [MISR_WIDTH-1:0] POLY       = MISR_WIDTH'(MISR_POLY)
) (
   input  logic                  CK,
   input  logic                  rstn,
   input  logic [MISR_WIDTH-1:0] din,
   input  logic                  en,
   input  logic                  clr,
   output logic [MISR_WIDTH-1:0] sig
);

   logic [MISR_WIDTH-1:0] fb;

   assign fb = sig[MISR_WIDTH-1] ? POLY : '0;

   // Clear wins over a fold in the same cycle.
   always_ff @(posedge CK or negedge rstn) begin
      if (!rstn) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= {sig[MISR_WIDTH-2:0], 1'b0} ^ fb ^ din;
      end
   end

endmodule

// File: rtl/scan_test_driver.sv
// Tester-side scan driver: load one pattern serially, capture, unload, return the response.
// Optional response signature when SCAN_DRV_MISR_EN is defined; otherwise sig is tied to 0.
module scan_test_driver
   import scan_drv_pkg::*;
#(
   parameter int CHAIN_LEN      = 3,
   parameter int PI_WIDTH       = 4,
   parameter int PO_WIDTH       = 1,
   parameter int CAPTURE_CYCLES = 1,
   parameter int MISR_WIDTH     = 16
) (
   input  logic                  CK,
   input  logic                  rstn,
   input  logic                  vec_valid,
   output logic                  vec_ready,
   input  logic [CHAIN_LEN-1:0]  vec_state,
   input  logic [PI_WIDTH-1:0]   vec_pi,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [CHAIN_LEN-1:0]  rsp_state,
   output logic [PO_WIDTH-1:0]   rsp_po,
   output logic [PI_WIDTH-1:0]   dut_pi,
   input  logic [PO_WIDTH-1:0]   dut_po,
   output logic                  shift_en,
   output logic                  sdi,
   input  logic                  sdo,
   output logic [MISR_WIDTH-1:0] sig,
   input  logic                  sig_clr
);

   localparam int CNT_W = $clog2(max2(CHAIN_LEN, CAPTURE_CYCLES) + 1);

   logic [2:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [CHAIN_LEN-1:0] pat;
   logic                 last;

   // NOTE: always_comb gives every output a default first, so no path can infer a latch.
   always_comb begin
      last = 1'b0;
      case (state)
         LOAD, UNLOAD: last = (cnt == CNT_W'(CHAIN_LEN - 1));
         CAPTURE:      last = (cnt == CNT_W'(CAPTURE_CYCLES - 1));
         default:      last = 1'b0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CK or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         pat       <= '0;
         dut_pi    <= '0;
         rsp_state <= '0;
         rsp_po    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (vec_valid) begin
                  pat    <= vec_state;
                  dut_pi <= vec_pi;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               pat <= pat >> 1;
               if (last) begin
                  cnt   <= '0;
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (last) begin
                  rsp_po <= dut_po;
                  cnt    <= '0;
                  state  <= UNLOAD;
               end
            end
            UNLOAD: begin
               // The first bit out of sdo is the flop nearest sdo, so it settles in bit 0.
               rsp_state <= (rsp_state >> 1) | (CHAIN_LEN'(sdo) << (CHAIN_LEN - 1));
               if (last) begin
                  cnt   <= '0;
                  state <= RESP;
               end
            end
            RESP: begin
               cnt <= '0;
               if (rsp_ready) state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign vec_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign shift_en  = (state == LOAD) || (state == UNLOAD);
   assign sdi       = (state == LOAD) && pat[0];

`ifdef SCAN_DRV_MISR_EN
   logic [MISR_WIDTH-1:0] misr_din;
   logic                  misr_en;

   always_comb begin
      misr_din = '0;
      misr_en  = 1'b0;
      if ((state == CAPTURE) && last) begin
         misr_en                 = 1'b1;
         misr_din[PO_WIDTH-1:0]  = dut_po;
      end else if (state == UNLOAD) begin
         misr_en     = 1'b1;
         misr_din[0] = sdo;
      end
   end

   scan_misr #(
      .MISR_WIDTH (MISR_WIDTH)
   ) u_misr (
      .CK   (CK),
      .rstn (rstn),
      .din  (misr_din),
      .en   (misr_en),
      .clr  (sig_clr),
      .sig  (sig)
   );
`else
   logic unused_sig_clr;

   assign unused_sig_clr = sig_clr;
   assign sig            = '0;
`endif

endmodule

// File: tb/tb_scan_test_driver.sv
// Scoreboard bench for scan_test_driver: behavioural scan-chain DUTs, reference model, monitors.
`timescale 1ns/1ps
module tb_scan_test_driver;

   localparam int L   = 3;
   localparam int C   = 1;
   localparam int PIW = 4;
   localparam int POW = 1;
   localparam int MW  = 16;
   localparam int LB  = 1;
   localparam int CB  = 2;

   logic CK = 1'b0;
   logic rstn = 1'b0;
   always #5 CK = ~CK;

   // main instance signals
   logic           vec_valid, vec_ready, rsp_valid, rsp_ready, shift_en, sdi, sdo, sig_clr;
   logic [L-1:0]   vec_state, rsp_state;
   logic [PIW-1:0] vec_pi, dut_pi;
   logic [POW-1:0] rsp_po, dut_po;
   logic [MW-1:0]  sig;

   // single-flop instance signals
   logic           b_vec_valid, b_vec_ready, b_rsp_valid, b_rsp_ready, b_shift_en, b_sdi, b_sdo;
   logic           b_sig_clr;
   logic [LB-1:0]  b_vec_state, b_rsp_state;
   logic [PIW-1:0] b_vec_pi, b_dut_pi;
   logic [POW-1:0] b_rsp_po, b_dut_po;
   logic [MW-1:0]  b_sig;

   scan_test_driver #(
      .CHAIN_LEN(L), .PI_WIDTH(PIW), .PO_WIDTH(POW), .CAPTURE_CYCLES(C), .MISR_WIDTH(MW)
   ) dut (
      .CK(CK), .rstn(rstn), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .vec_state(vec_state), .vec_pi(vec_pi), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_state(rsp_state), .rsp_po(rsp_po), .dut_pi(dut_pi), .dut_po(dut_po),
      .shift_en(shift_en), .sdi(sdi), .sdo(sdo), .sig(sig), .sig_clr(sig_clr)
   );

   scan_test_driver #(
      .CHAIN_LEN(LB), .PI_WIDTH(PIW), .PO_WIDTH(POW), .CAPTURE_CYCLES(CB), .MISR_WIDTH(MW)
   ) dut_b (
      .CK(CK), .rstn(rstn), .vec_valid(b_vec_valid), .vec_ready(b_vec_ready),
      .vec_state(b_vec_state), .vec_pi(b_vec_pi), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_state(b_rsp_state), .rsp_po(b_rsp_po), .dut_pi(b_dut_pi), .dut_po(b_dut_po),
      .shift_en(b_shift_en), .sdi(b_sdi), .sdo(b_sdo), .sig(b_sig), .sig_clr(b_sig_clr)
   );

   // Circuit under test, 3 flops: capture loads state ^ 3'b101, po = ^state.
   logic [L-1:0] chain = '0;
   always @(posedge CK) chain <= shift_en ? {sdi, chain[L-1:1]} : (chain ^ 3'b101);
   assign sdo    = chain[0];
   assign dut_po = ^chain;

   // Circuit under test, 1 flop: capture loads state & pi[0], po = state.
   logic chain_b = 1'b0;
   always @(posedge CK) chain_b <= b_shift_en ? b_sdi : (chain_b & b_dut_pi[0]);
   assign b_sdo    = chain_b;
   assign b_dut_po = chain_b;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [L-1:0]  st;
      logic          po;
      logic [MW-1:0] sig;
   } exp_t;

   typedef struct packed {
      logic [LB-1:0] st;
      logic          po;
   } exp_b_t;

   exp_t   q_a[$];
   exp_b_t q_b[$];
   exp_t   mon_a;
   exp_b_t mon_b;
   logic [MW-1:0] ref_sig = '0;

   function automatic logic [MW-1:0] misr_fold(input logic [MW-1:0] s, input logic [MW-1:0] d);
      logic [MW-1:0] n;
      n = (s << 1) ^ d;
      if (s[MW-1]) n = n ^ 16'h8016;
      return n;
   endfunction

   // Reference: apply C captures to the loaded state; signature events indexed by cycle after accept.
   function automatic exp_t model_a(input logic [L-1:0] v, input int clr_at);
      exp_t         e;
      logic [L-1:0] s;
      s     = v;
      e.po  = 1'b0;
      e.sig = ref_sig;
      for (int c = 0; c < C; c++) begin
         e.po = ^s;
         s    = s ^ 3'b101;
      end
      e.st = s;
`ifdef SCAN_DRV_MISR_EN
      for (int n = 1; n <= 2*L + C; n++) begin
         if (n == clr_at)     e.sig = '0;
         else if (n == L + C) e.sig = misr_fold(e.sig, MW'(e.po));
         else if (n > L + C)  e.sig = misr_fold(e.sig, MW'(s[n-L-C-1]));
      end
`else
      e.sig = '0;
`endif
      return e;
   endfunction

   function automatic exp_b_t model_b(input logic [LB-1:0] v, input logic [PIW-1:0] pi);
      exp_b_t e;
      logic   s;
      s    = v[0];
      e.po = 1'b0;
      for (int c = 0; c < CB; c++) begin
         e.po = s;
         s    = s & pi[0];
      end
      e.st = s;
      return e;
   endfunction

   // Monitors: pop expected response on every completed response handshake.
   always @(negedge CK) begin
      if (rstn && rsp_valid && rsp_ready) begin
         if (q_a.size() == 0) begin
            check("rsp_unexpected", 1, 0);
         end else begin
            mon_a = q_a.pop_front();
            check("rsp_state", rsp_state, mon_a.st);
            check("rsp_po", rsp_po, mon_a.po);
            check("sig", sig, mon_a.sig);
         end
      end
   end

   always @(negedge CK) begin
      if (rstn && b_rsp_valid && b_rsp_ready) begin
         if (q_b.size() == 0) begin
            check("b_rsp_unexpected", 1, 0);
         end else begin
            mon_b = q_b.pop_front();
            check("b_rsp_state", b_rsp_state, mon_b.st);
            check("b_rsp_po", b_rsp_po, mon_b.po);
         end
      end
   end

   // hold > 0: keep rsp_ready low that many extra cycles then release; hold < 0: leave in RESP.
   task automatic run_a(input logic [L-1:0] v, input logic [PIW-1:0] pi,
                        input int hold, input int clr_at, output int waited);
      exp_t e;
      vec_state = v;
      vec_pi    = pi;
      vec_valid = 1'b1;
      waited    = 0;
      @(negedge CK);
      while (!vec_ready && waited < 40) begin
         @(negedge CK);
         waited++;
      end
      check("accept_ready", vec_ready, 1'b1);
      @(posedge CK); #1;
      vec_valid = 1'b0;
      e = model_a(v, clr_at);
      q_a.push_back(e);
      ref_sig   = e.sig;
      rsp_ready = (hold == 0);
      for (int n = 1; n <= 2*L + C + 1; n++) begin
         sig_clr = (n == clr_at);
         @(negedge CK);
         check("sdi", sdi, (n <= L) ? v[n-1] : 1'b0);
         check("shift_en", shift_en, (n <= L) || (n > L + C && n <= 2*L + C));
         check("rsp_valid_latency", rsp_valid, n == 2*L + C + 1);
         check("vec_ready_busy", vec_ready, 1'b0);
         check("dut_pi", dut_pi, pi);
         @(posedge CK); #1;
      end
      sig_clr = 1'b0;
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge CK);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_state", rsp_state, e.st);
            check("hold_rsp_po", rsp_po, e.po);
            check("hold_vec_ready", vec_ready, 1'b0);
            check("hold_shift_en", shift_en, 1'b0);
            @(posedge CK); #1;
         end
         rsp_ready = 1'b1;
         @(negedge CK);
         @(posedge CK); #1;
         @(negedge CK);
         check("release_idle", {vec_ready, rsp_valid}, 2'b10);
         @(posedge CK); #1;
      end
   endtask

   task automatic run_b(input logic [LB-1:0] v, input logic [PIW-1:0] pi);
      int waited;
      b_vec_state = v;
      b_vec_pi    = pi;
      b_vec_valid = 1'b1;
      waited      = 0;
      @(negedge CK);
      while (!b_vec_ready && waited < 40) begin
         @(negedge CK);
         waited++;
      end
      check("b_accept_ready", b_vec_ready, 1'b1);
      @(posedge CK); #1;
      b_vec_valid = 1'b0;
      q_b.push_back(model_b(v, pi));
      for (int n = 1; n <= 2*LB + CB + 1; n++) begin
         @(negedge CK);
         check("b_shift_en", b_shift_en, (n <= LB) || (n > LB + CB && n <= 2*LB + CB));
         check("b_rsp_valid_latency", b_rsp_valid, n == 2*LB + CB + 1);
         check("b_sdi", b_sdi, (n <= LB) ? v[0] : 1'b0);
         @(posedge CK); #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w;
      bit  seen;
      logic [L-1:0]   rv;
      logic [PIW-1:0] rp;

      vec_valid = 1'b0; vec_state = '0; vec_pi = '0; rsp_ready = 1'b1; sig_clr = 1'b0;
      b_vec_valid = 1'b0; b_vec_state = '0; b_vec_pi = '0; b_rsp_ready = 1'b1; b_sig_clr = 1'b0;

      repeat (3) @(posedge CK);
      @(negedge CK);
      check("rst_vec_ready", vec_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_shift_en", shift_en, 1'b0);
      check("rst_sdi", sdi, 1'b0);
      check("rst_dut_pi", dut_pi, '0);
      check("rst_rsp_state", rsp_state, '0);
      check("rst_rsp_po", rsp_po, '0);
      check("rst_sig", sig, '0);
      @(posedge CK); #1;
      rstn = 1'b1;

      // Reset in LOAD cycle 1 abandons the pattern.
      vec_state = 3'b011; vec_pi = 4'h5; vec_valid = 1'b1;
      @(negedge CK);
      @(posedge CK); #1;
      vec_valid = 1'b0;
      @(posedge CK); #1;
      rstn = 1'b0;
      @(negedge CK);
      check("midload_shift_en", shift_en, 1'b0);
      check("midload_vec_ready", vec_ready, 1'b1);
      check("midload_rsp_valid", rsp_valid, 1'b0);
      @(posedge CK); #1;
      rstn    = 1'b1;
      ref_sig = '0;
      seen    = 1'b0;
      repeat (12) begin
         @(negedge CK);
         if (rsp_valid) seen = 1'b1;
      end
      check("midload_no_rsp", seen, 1'b0);
      @(posedge CK); #1;

      // Directed pattern: sdi 0,1,1; response 011 / po 0 / dut_pi A; valid in cycle 8.
      run_a(3'b110, 4'hA, 0, 0, w);

      // Backpressure for 5 cycles.
      run_a(3'b001, 4'h3, 5, 0, w);

      // Release and new pattern offered together: accept only on the following edge.
      run_a(3'b101, 4'h6, -1, 0, w);
      vec_state = 3'b010; vec_pi = 4'h9; vec_valid = 1'b1; rsp_ready = 1'b1;
      @(negedge CK);
      check("ovl_no_accept_in_resp", vec_ready, 1'b0);
      @(posedge CK); #1;
      run_a(3'b010, 4'h9, 0, 0, w);
      check("ovl_accept_next_cycle", w, 0);

      // Signature clear in idle, then a clear colliding with the last unload fold.
      sig_clr = 1'b1;
      @(posedge CK); #1;
      sig_clr = 1'b0;
      ref_sig = '0;
      @(negedge CK);
      check("sig_clr_idle", sig, '0);
      @(posedge CK); #1;
      run_a(3'b111, 4'h1, 0, 2*L + C, w);

      // Randomized back-to-back patterns with random backpressure.
      for (int i = 0; i < 24; i++) begin
         rv = L'($urandom_range(0, 7));
         rp = PIW'($urandom_range(0, 15));
         run_a(rv, rp, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 0, w);
      end

      // Single-flop chain with two capture cycles.
      run_b(1'b1, 4'hA);
      for (int i = 0; i < 6; i++) begin
         run_b(LB'($urandom_range(0, 1)), PIW'($urandom_range(0, 15)));
      end

      repeat (4) @(posedge CK);
      #1;
      check("q_a_drained", q_a.size(), 0);
      check("q_b_drained", q_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
